// File: rtl/tmr_seq_pkg.sv
// Shared definitions for the interval-timer Avalon-MM sequencer:
// FSM state encoding, timer register map and control words.
package tmr_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        WR_STOP,
        WR_CLR,
        ACK,
        SNAP_WR,
        SNAP_RL,
        SNAP_RH,
        SNAP_CAP
    } state_e;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    localparam logic [15:0] CTRL_START_CONT_ITO = 16'h0007;
    localparam logic [15:0] CTRL_STOP           = 16'h0008;

endpackage

// File: rtl/timer_avalon_sequencer.sv
// Avalon-MM master that programs, stops, services and snapshots the interval timer.
// Optional snapshot support is built only when TMR_SEQ_SNAPSHOT_EN is defined.
module timer_avalon_sequencer
    import tmr_seq_pkg::*;
#(
    parameter logic [31:0] INIT_PERIOD = 32'd49999,
    parameter bit          AUTO_START  = 1'b1,
    parameter int          TICK_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_stop,
    input  logic              snap_req,
    output logic              busy,
    output logic              cfg_err,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              snap_valid,
    output logic [31:0]       snap_value,
    output logic [2:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic [15:0]       tmr_readdata,
    input  logic              tmr_irq
);

    localparam state_e      RESET_STATE  = AUTO_START ? WR_PL : IDLE;
    localparam logic [31:0] RESET_PERIOD = AUTO_START ? INIT_PERIOD : 32'd0;

    state_e              state_q, state_d;
    logic                start_pend_q, start_pend_d;
    logic                stop_pend_q, stop_pend_d;
    logic [31:0]         period_q, period_d;
    logic [31:0]         cur_period_q, cur_period_d;
    logic                busy_q, busy_d;
    logic                cfg_err_q, cfg_err_d;
    logic                tick_q, tick_d;
    logic [TICK_W-1:0]   tick_count_q, tick_count_d;
    logic [2:0]          addr_q, addr_d;
    logic                cs_q, cs_d;
    logic                write_n_q, write_n_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                start_new, start_take, stop_take;
    logic                snap_busy;

`ifdef TMR_SEQ_SNAPSHOT_EN
    logic                snap_pend_q, snap_pend_d;
    logic                snap_take;
    logic [15:0]         snap_lo_q, snap_lo_d;
    logic [31:0]         snap_value_q, snap_value_d;
    logic                snap_valid_q, snap_valid_d;
`endif

    // Next state, request bookkeeping and registered bus decode of the next state.
    always_comb begin
        state_d      = state_q;
        cur_period_d = cur_period_q;
        start_take   = 1'b0;
        stop_take    = 1'b0;
`ifdef TMR_SEQ_SNAPSHOT_EN
        snap_take    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (tmr_irq) begin
                    state_d = ACK;
                end else if (stop_pend_q) begin
                    state_d   = WR_STOP;
                    stop_take = 1'b1;
                end else if (start_pend_q) begin
                    state_d      = WR_PL;
                    start_take   = 1'b1;
                    cur_period_d = period_q;
`ifdef TMR_SEQ_SNAPSHOT_EN
                end else if (snap_pend_q) begin
                    state_d   = SNAP_WR;
                    snap_take = 1'b1;
`endif
                end
            end
            // Straight out of reset the bus has not yet presented the low
            // period write, so hold here one cycle to issue it.
            WR_PL:    state_d = cs_q ? WR_PH : WR_PL;
            WR_PH:    state_d = WR_CTRL;
            WR_CTRL:  state_d = IDLE;
            WR_STOP:  state_d = WR_CLR;
            WR_CLR:   state_d = IDLE;
            ACK:      state_d = IDLE;
`ifdef TMR_SEQ_SNAPSHOT_EN
            SNAP_WR:  state_d = SNAP_RL;
            SNAP_RL:  state_d = SNAP_RH;
            SNAP_RH:  state_d = SNAP_CAP;
            SNAP_CAP: state_d = IDLE;
`endif
            default:  state_d = IDLE;
        endcase

        // Stop beats a simultaneous start; a zero period is rejected outright.
        start_new    = cfg_start && !cfg_stop && (cfg_period != 32'd0);
        cfg_err_d    = cfg_start && !cfg_stop && (cfg_period == 32'd0);
        start_pend_d = (start_pend_q && !start_take) || start_new;
        stop_pend_d  = (stop_pend_q && !stop_take) || cfg_stop;
        period_d     = start_new ? cfg_period : period_q;

        tick_d       = (state_q == ACK);
        tick_count_d = tick_d ? tick_count_q + 1'b1 : tick_count_q;

        cs_d      = 1'b0;
        write_n_d = 1'b1;
        addr_d    = ADDR_STATUS;
        wdata_d   = 16'h0000;
        case (state_d)
            WR_PL:   begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_PERIOD_L; wdata_d = cur_period_d[15:0];  end
            WR_PH:   begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_PERIOD_H; wdata_d = cur_period_d[31:16]; end
            WR_CTRL: begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_CONTROL;  wdata_d = CTRL_START_CONT_ITO; end
            WR_STOP: begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_CONTROL;  wdata_d = CTRL_STOP;           end
            WR_CLR:  begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_STATUS;                                   end
            ACK:     begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_STATUS;                                   end
`ifdef TMR_SEQ_SNAPSHOT_EN
            SNAP_WR: begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = ADDR_SNAP_L; end
            SNAP_RL: begin cs_d = 1'b1;                   addr_d = ADDR_SNAP_L; end
            SNAP_RH: begin cs_d = 1'b1;                   addr_d = ADDR_SNAP_H; end
`endif
            default: ;
        endcase

        busy_d = (state_d != IDLE) || start_pend_d || stop_pend_d || snap_busy;
    end

`ifdef TMR_SEQ_SNAPSHOT_EN
    // Read data lags its address by a cycle: low half lands at the end of
    // SNAP_RH, high half at the end of SNAP_CAP.
    always_comb begin
        snap_pend_d  = (snap_pend_q && !snap_take) || snap_req;
        snap_lo_d    = (state_q == SNAP_RH) ? tmr_readdata : snap_lo_q;
        snap_valid_d = (state_q == SNAP_CAP);
        snap_value_d = snap_valid_d ? {tmr_readdata, snap_lo_q} : snap_value_q;
        snap_busy    = snap_pend_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_pend_q  <= 1'b0;
            snap_lo_q    <= 16'h0000;
            snap_value_q <= 32'd0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_pend_q  <= snap_pend_d;
            snap_lo_q    <= snap_lo_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign snap_valid = snap_valid_q;
    assign snap_value = snap_value_q;
`else
    logic unused_snap;
    assign unused_snap = ^{snap_req, tmr_readdata};
    assign snap_busy   = 1'b0;
    assign snap_valid  = 1'b0;
    assign snap_value  = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            start_pend_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            period_q     <= RESET_PERIOD;
            cur_period_q <= RESET_PERIOD;
            busy_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
            cs_q         <= 1'b0;
            write_n_q    <= 1'b1;
            addr_q       <= ADDR_STATUS;
            wdata_q      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            start_pend_q <= start_pend_d;
            stop_pend_q  <= stop_pend_d;
            period_q     <= period_d;
            cur_period_q <= cur_period_d;
            busy_q       <= busy_d;
            cfg_err_q    <= cfg_err_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            cs_q         <= cs_d;
            write_n_q    <= write_n_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign busy           = busy_q;
    assign cfg_err        = cfg_err_q;
    assign tick           = tick_q;
    assign tick_count     = tick_count_q;
    assign tmr_address    = addr_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = write_n_q;
    assign tmr_writedata  = wdata_q;

endmodule
